// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC selection (PC+4 / branch / jump / jr), stall, halt, misaligned-jr detection.
// Optional MIPS branch delay slot enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] Shiftby2,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        branch_taken,
    output logic        misaligned,
    output logic        halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic        mis_r;
    logic        mis_nxt_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;
    logic [31:0] jr_tgt_s;
    logic [31:0] sel_tgt_s;
    logic        redirect_s;
    logic        jr_mis_s;
    logic        run_s;
`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_r;
    logic        pend_nxt_s;
    logic [31:0] ptgt_r;
    logic [31:0] ptgt_nxt_s;
`endif

    assign pc_plus4_s = pc_r + 32'd4;
    assign br_tgt_s   = pc_plus4_s + Shiftby2;
    assign j_tgt_s    = {pc_plus4_s[31:28], instr_index, 2'b00};
    assign jr_tgt_s   = {rs_data[31:2], 2'b00};
    assign jr_mis_s   = JumpReg & (rs_data[1:0] != 2'b00);
    assign run_s      = (state_r == ST_RUN) & ~stall;

    // Redirect target selection: JumpReg > Jump > taken branch > sequential.
    always_comb begin
        redirect_s = 1'b1;
        sel_tgt_s  = pc_plus4_s;
        if (JumpReg) begin
            sel_tgt_s = jr_tgt_s;
        end else if (Jump) begin
            sel_tgt_s = j_tgt_s;
        end else if (Branch & Zero) begin
            sel_tgt_s = br_tgt_s;
        end else begin
            redirect_s = 1'b0;
            sel_tgt_s  = pc_plus4_s;
        end
    end

    // Next-state, next-PC and misaligned-pulse logic of the RUN/HALT machine.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        mis_nxt_s   = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_nxt_s  = pend_r;
        ptgt_nxt_s  = ptgt_r;
`endif
        case (state_r)
            ST_RUN: begin
                if (stall) begin
                    mis_nxt_s = 1'b0;
                end else if (halt) begin
                    state_nxt_s = ST_HALT;
`ifdef BRANCH_DELAY_SLOT_EN
                    pend_nxt_s  = 1'b0;
`endif
                end else begin
`ifdef BRANCH_DELAY_SLOT_EN
                    // The delay-slot instruction has already been fetched; any redirect now is ignored.
                    if (pend_r) begin
                        pc_nxt_s   = ptgt_r;
                        pend_nxt_s = 1'b0;
                    end else begin
                        mis_nxt_s = jr_mis_s;
                        if (jr_mis_s && HALT_ON_MISALIGN) begin
                            state_nxt_s = ST_HALT;
                        end else if (redirect_s) begin
                            pend_nxt_s = 1'b1;
                            ptgt_nxt_s = sel_tgt_s;
                            pc_nxt_s   = pc_plus4_s;
                        end else begin
                            pc_nxt_s = pc_plus4_s;
                        end
                    end
`else
                    mis_nxt_s = jr_mis_s;
                    if (jr_mis_s && HALT_ON_MISALIGN) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        pc_nxt_s = sel_tgt_s;
                    end
`endif
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // PC, state and misaligned-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_PC;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            mis_r   <= mis_nxt_s;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // Pending delay-slot redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
            ptgt_r <= 32'h0000_0000;
        end else begin
            pend_r <= pend_nxt_s;
            ptgt_r <= ptgt_nxt_s;
        end
    end

    assign branch_taken = Branch & Zero & run_s & ~pend_r;
`else
    assign branch_taken = Branch & Zero & run_s;
`endif

    assign PC         = pc_r;
    assign PC_plus4   = pc_plus4_s;
    assign misaligned = mis_r;
    assign halted     = (state_r == ST_HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Testbench for pc_next_unit: directed scenarios plus randomized run against a behavioural model.
// dut0 halts on misaligned jr, dut1 aligns and continues.
module tb_pc_next_unit;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic        Jump = 1'b0;
    logic        JumpReg = 1'b0;
    logic [31:0] Shiftby2 = 32'h0;
    logic [25:0] instr_index = 26'h0;
    logic [31:0] rs_data = 32'h0;

    logic [31:0] pc_w [2];
    logic [31:0] p4_w [2];
    logic        bt_w [2];
    logic        mis_w [2];
    logic        hlt_w [2];

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0] m_pc [2];
    logic [31:0] m_tgt [2];
    bit          m_halt [2];
    bit          m_mis [2];
    bit          m_pend [2];

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(32'h0000_0000), .HALT_ON_MISALIGN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .JumpReg(JumpReg), .Shiftby2(Shiftby2), .instr_index(instr_index),
        .rs_data(rs_data), .PC(pc_w[0]), .PC_plus4(p4_w[0]), .branch_taken(bt_w[0]),
        .misaligned(mis_w[0]), .halted(hlt_w[0]));

    pc_next_unit #(.RESET_PC(32'h0000_0000), .HALT_ON_MISALIGN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .Branch(Branch), .Zero(Zero),
        .Jump(Jump), .JumpReg(JumpReg), .Shiftby2(Shiftby2), .instr_index(instr_index),
        .rs_data(rs_data), .PC(pc_w[1]), .PC_plus4(p4_w[1]), .branch_taken(bt_w[1]),
        .misaligned(mis_w[1]), .halted(hlt_w[1]));

    task automatic idle();
        stall = 1'b0; halt = 1'b0; Branch = 1'b0; Zero = 1'b0;
        Jump = 1'b0; JumpReg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Load an arbitrary PC through an aligned jr (plus the delay slot when built).
    task automatic goto(input logic [31:0] addr);
        idle();
        JumpReg = 1'b1;
        rs_data = addr;
        tick();
        idle();
        if (DS) tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_tgt[i] = 32'h0;
            m_halt[i] = 1'b0; m_mis[i] = 1'b0; m_pend[i] = 1'b0;
        end
    endtask

    // Behavioural next-PC rules applied to the current inputs for both configurations.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] p4;
            logic [31:0] tgt;
            bit redir;
            bit mis;
            p4 = m_pc[i] + 32'd4;
            mis = 1'b0;
            if (!m_halt[i] && !stall) begin
                if (halt) begin
                    m_halt[i] = 1'b1;
                    m_pend[i] = 1'b0;
                end else if (m_pend[i]) begin
                    m_pc[i] = m_tgt[i];
                    m_pend[i] = 1'b0;
                end else begin
                    redir = 1'b1;
                    if (JumpReg) begin
                        tgt = rs_data & 32'hFFFF_FFFC;
                        mis = (rs_data % 4) != 0;
                    end else if (Jump) begin
                        tgt = (p4 & 32'hF000_0000) + ({6'd0, instr_index} * 32'd4);
                    end else if (Branch && Zero) begin
                        tgt = p4 + Shiftby2;
                    end else begin
                        redir = 1'b0;
                        tgt = p4;
                    end
                    if (mis && i == 0) begin
                        m_halt[i] = 1'b1;
                    end else if (redir && DS) begin
                        m_pend[i] = 1'b1;
                        m_tgt[i] = tgt;
                        m_pc[i] = p4;
                    end else begin
                        m_pc[i] = tgt;
                    end
                end
            end
            m_mis[i] = mis;
        end
    endtask

    task automatic test_reset();
        do_reset();
        goto(32'h0000_0040);
        JumpReg = 1'b1; rs_data = 32'h0000_0203;
        tick();
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (pc_w[i] !== 32'h0) $display("FAIL reset_pc dut%0d: got %h want 00000000", i, pc_w[i]);
            else n_pass++;
            n_chk++;
            if (hlt_w[i] !== 1'b0) $display("FAIL reset_halted dut%0d: got %b want 0", i, hlt_w[i]);
            else n_pass++;
            n_chk++;
            if (mis_w[i] !== 1'b0) $display("FAIL reset_misaligned dut%0d: got %b want 0", i, mis_w[i]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fetch();
        do_reset();
        idle();
        tick();
        n_chk++;
        if (pc_w[0] !== 32'h4) $display("FAIL seq_pc1: got %h want 00000004", pc_w[0]);
        else n_pass++;
        for (int k = 2; k <= 3; k++) begin
            tick();
            n_chk++;
            if (pc_w[0] !== 32'(4 * k)) $display("FAIL seq_pc%0d: got %h want %h", k, pc_w[0], 32'(4 * k));
            else n_pass++;
        end
        goto(32'hFFFF_FFFC);
        #1;
        n_chk++;
        if (p4_w[0] !== 32'h0) $display("FAIL wrap_plus4: got %h want 00000000", p4_w[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (pc_w[0] !== 32'h0) $display("FAIL wrap_pc: got %h want 00000000", pc_w[0]);
        else n_pass++;
    endtask

    task automatic test_branch();
        goto(32'h0000_0010);
        Branch = 1'b1; Zero = 1'b1; Shiftby2 = 32'hFFFF_FFF0;
        #1;
        n_chk++;
        if (bt_w[0] !== 1'b1) $display("FAIL branch_taken: got %b want 1", bt_w[0]);
        else n_pass++;
        tick();
        if (DS) begin
            n_chk++;
            if (pc_w[0] !== 32'h14) $display("FAIL branch_slot_pc: got %h want 00000014", pc_w[0]);
            else n_pass++;
            #1;
            n_chk++;
            if (bt_w[0] !== 1'b0) $display("FAIL branch_taken_pending: got %b want 0", bt_w[0]);
            else n_pass++;
            tick();
        end
        idle();
        n_chk++;
        if (pc_w[0] !== 32'h4) $display("FAIL branch_pc: got %h want 00000004", pc_w[0]);
        else n_pass++;
    endtask

    task automatic test_priority();
        goto(32'h0000_0020);
        JumpReg = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
        rs_data = 32'h0000_0100; instr_index = 26'h3; Shiftby2 = 32'h40;
        tick();
        idle();
        if (DS) tick();
        n_chk++;
        if (pc_w[0] !== 32'h100) $display("FAIL prio_jr_pc: got %h want 00000100", pc_w[0]);
        else n_pass++;
        goto(32'h1000_0000);
        Jump = 1'b1; instr_index = 26'h40;
        tick();
        idle();
        if (DS) tick();
        n_chk++;
        if (pc_w[0] !== 32'h1000_0100) $display("FAIL jump_pc: got %h want 10000100", pc_w[0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        goto(32'h0000_0080);
        stall = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1; instr_index = 26'h55;
        #1;
        n_chk++;
        if (bt_w[0] !== 1'b0) $display("FAIL stall_branch_taken: got %b want 0", bt_w[0]);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++;
            if (pc_w[0] !== 32'h80) $display("FAIL stall_pc%0d: got %h want 00000080", k, pc_w[0]);
            else n_pass++;
        end
        idle();
        tick();
        n_chk++;
        if (pc_w[0] !== 32'h84) $display("FAIL stall_release_pc: got %h want 00000084", pc_w[0]);
        else n_pass++;
    endtask

    task automatic test_halt();
        goto(32'h0000_0060);
        halt = 1'b1; Jump = 1'b1; instr_index = 26'h11;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (hlt_w[i] !== 1'b1) $display("FAIL halt_enter dut%0d: got %b want 1", i, hlt_w[i]);
            else n_pass++;
        end
        halt = 1'b0; JumpReg = 1'b1; rs_data = 32'h400;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) halt = 1'b1;
            tick();
            n_chk++;
            if (pc_w[0] !== 32'h60) $display("FAIL halt_frozen_pc%0d: got %h want 00000060", k, pc_w[0]);
            else n_pass++;
        end
        idle();
        do_reset();
        #1;
        n_chk++;
        if (hlt_w[0] !== 1'b0) $display("FAIL halt_exit_reset: got %b want 0", hlt_w[0]);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        goto(32'h0000_0040);
        JumpReg = 1'b1; rs_data = 32'h0000_0203;
        tick();
        idle();
        n_chk++;
        if (hlt_w[0] !== 1'b1 || pc_w[0] !== 32'h40)
            $display("FAIL mis_halt dut0: got halted=%b pc=%h want halted=1 pc=00000040", hlt_w[0], pc_w[0]);
        else n_pass++;
        n_chk++;
        if (mis_w[0] !== 1'b1 || mis_w[1] !== 1'b1)
            $display("FAIL mis_pulse: got %b%b want 11", mis_w[0], mis_w[1]);
        else n_pass++;
        n_chk++;
        if (pc_w[1] !== (DS ? 32'h44 : 32'h200)) $display("FAIL mis_align_pc dut1: got %h want %h", pc_w[1], DS ? 32'h44 : 32'h200);
        else n_pass++;
        tick();
        n_chk++;
        if (mis_w[0] !== 1'b0 || mis_w[1] !== 1'b0)
            $display("FAIL mis_one_cycle: got %b%b want 00", mis_w[0], mis_w[1]);
        else n_pass++;
        n_chk++;
        if (pc_w[1] !== (DS ? 32'h200 : 32'h204)) $display("FAIL mis_continue_pc dut1: got %h want %h", pc_w[1], DS ? 32'h200 : 32'h204);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            if (((m_halt[0] || m_halt[1]) && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
                model_reset();
            end
            stall   = ($urandom_range(0, 4) == 0);
            halt    = ($urandom_range(0, 39) == 0);
            Branch  = ($urandom_range(0, 9) < 4);
            Zero    = $urandom_range(0, 1) == 1;
            Jump    = ($urandom_range(0, 6) == 0);
            JumpReg = ($urandom_range(0, 6) == 0);
            Shiftby2 = $urandom << 2;
            instr_index = 26'($urandom);
            rs_data = $urandom;
            if ($urandom_range(0, 3) != 0) rs_data = rs_data & 32'hFFFF_FFFC;
            #1;
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (p4_w[i] !== m_pc[i] + 32'd4)
                    $display("FAIL rnd_plus4 dut%0d cyc%0d: got %h want %h", i, c, p4_w[i], m_pc[i] + 32'd4);
                else n_pass++;
                n_chk++;
                if (bt_w[i] !== (Branch && Zero && !stall && !m_halt[i] && !m_pend[i]))
                    $display("FAIL rnd_branch_taken dut%0d cyc%0d: got %b want %b", i, c, bt_w[i],
                             Branch && Zero && !stall && !m_halt[i] && !m_pend[i]);
                else n_pass++;
            end
            model_step();
            tick();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (pc_w[i] !== m_pc[i]) $display("FAIL rnd_pc dut%0d cyc%0d: got %h want %h", i, c, pc_w[i], m_pc[i]);
                else n_pass++;
                n_chk++;
                if (hlt_w[i] !== m_halt[i]) $display("FAIL rnd_halted dut%0d cyc%0d: got %b want %b", i, c, hlt_w[i], m_halt[i]);
                else n_pass++;
                n_chk++;
                if (mis_w[i] !== m_mis[i]) $display("FAIL rnd_misaligned dut%0d cyc%0d: got %b want %b", i, c, mis_w[i], m_mis[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        idle();
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_seq_fetch();
        test_branch();
        test_priority();
        test_stall();
        test_halt();
        test_misaligned();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
